// File: rtl/typing_scorer_pkg.sv
// Shared definitions for the typing scorer.
//   state_t              - scorer FSM state encoding
//   DEFAULT_TICKS_PER_MS - clk cycles per millisecond at 100 MHz
//   MAX_LEN              - capacity of the target sequence
//   TARGET_SEQ           - digits the user is asked to type, in order
package typing_scorer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int DEFAULT_TICKS_PER_MS = 100_000;
  localparam int MAX_LEN              = 16;

  localparam logic [3:0] TARGET_SEQ [MAX_LEN] = '{
    4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8,
    4'd9, 4'd0, 4'd2, 4'd7, 4'd1, 4'd8, 4'd2, 4'd8
  };

endpackage

// File: rtl/typing_scorer_if.sv
// Keypad-side and score-side signals of the typing scorer.
//   master : drives start, key_code, key_valid; observes the score outputs
//   slave  : the scorer itself
interface typing_scorer_if;
  logic        start;
  logic [3:0]  key_code;
  logic        key_valid;
  logic [3:0]  expected;
  logic [4:0]  position;
  logic [4:0]  correct_count;
  logic [7:0]  error_count;
  logic [15:0] elapsed_ms;
  logic        busy;
  logic        done;
  logic        score_valid;

  modport master (
    output start, key_code, key_valid,
    input  expected, position, correct_count, error_count,
           elapsed_ms, busy, done, score_valid
  );

  modport slave (
    input  start, key_code, key_valid,
    output expected, position, correct_count, error_count,
           elapsed_ms, busy, done, score_valid
  );
endinterface

// File: rtl/typing_scorer_ms_tick.sv
// Millisecond prescaler: counts 0..TICKS_PER_MS-1 while enabled and raises
// tick during the last count, so a consumer sees one tick per millisecond.
//   clk, rst : clock and synchronous active-high reset
//   clear    : return the count to 0 (takes precedence over enable)
//   enable   : advance the count
//   tick     : high in the cycle that wraps the count
module ms_tick_gen #(
  parameter int TICKS_PER_MS = 100_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int CNT_W = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;

  logic [CNT_W-1:0] cnt;

  assign tick = enable && (cnt == CNT_W'(TICKS_PER_MS - 1));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/typing_scorer.sv
// Typing-speed/accuracy scorer. After start, the user types the digits of
// TARGET_SEQ; each new key press is scored as correct (advances position) or
// wrong (counts an error). Timing runs in milliseconds from the first key
// to the last correct digit.
//   clk, rst : clock and synchronous active-high reset
//   bus      : start/key inputs and score/status outputs (slave modport)
module typing_scorer
  import typing_scorer_pkg::*;
#(
  parameter int TEST_LEN     = 16,
  parameter int TICKS_PER_MS = DEFAULT_TICKS_PER_MS
) (
  input  logic            clk,
  input  logic            rst,
  typing_scorer_if.slave  bus
);

  state_t      state, state_nxt;
  logic        key_valid_p1;
  logic        key_evt;
  logic        scoring;
  logic        key_hit;
  logic        last_hit;
  logic        run_en;
  logic        clear_cnt;
  logic        ms_tick;
  logic [3:0]  target;
  logic [4:0]  position;
  logic [4:0]  correct_count;
  logic [7:0]  error_count;
  logic [15:0] elapsed_ms;
  logic        score_valid;
  logic        busy;
  logic        done;

  // Stage p1: registered key_valid for rising-edge detection. It resets high
  // so a key held through reset never counts as a fresh press.
  always_ff @(posedge clk) begin
    if (rst) key_valid_p1 <= 1'b1;
    else     key_valid_p1 <= bus.key_valid;
  end

  assign key_evt  = bus.key_valid & ~key_valid_p1;
  // start beats a simultaneous key, which is discarded
  assign scoring  = key_evt & ~bus.start & ((state == ST_ARMED) || (state == ST_RUN));
  assign target   = (position < 5'(TEST_LEN)) ? TARGET_SEQ[position[3:0]] : 4'd0;
  assign key_hit  = (bus.key_code == target);
  assign last_hit = key_hit && (position == 5'(TEST_LEN - 1));

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // FSM next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (bus.start) state_nxt = ST_ARMED;
      end
      ST_ARMED, ST_RUN: begin
        if (bus.start)    state_nxt = ST_ARMED;
        else if (key_evt) state_nxt = last_hit ? ST_DONE : ST_RUN;
      end
      ST_DONE: begin
        if (bus.start) state_nxt = ST_ARMED;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy = (state == ST_ARMED) || (state == ST_RUN);
    done = (state == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) score_valid <= 1'b0;
    else     score_valid <= (state_nxt == ST_DONE) && (state != ST_DONE);
  end

  // The prescaler only runs in RUN and is held at 0 otherwise, so the first
  // millisecond is measured from the key that started the run.
  assign run_en    = (state == ST_RUN);
  assign clear_cnt = bus.start | ~run_en;

  ms_tick_gen #(
    .TICKS_PER_MS (TICKS_PER_MS)
  ) u_ms_tick (
    .clk    (clk),
    .rst    (rst),
    .clear  (clear_cnt),
    .enable (run_en),
    .tick   (ms_tick)
  );

  always_ff @(posedge clk) begin
    if (rst || bus.start) begin
      position      <= '0;
      correct_count <= '0;
      error_count   <= '0;
      elapsed_ms    <= '0;
    end else begin
      if (scoring) begin
        if (key_hit) begin
          position      <= position + 1'b1;
          correct_count <= correct_count + 1'b1;
        end else if (error_count != 8'hFF) begin
          error_count   <= error_count + 1'b1;
        end
      end
      if (run_en && ms_tick && (elapsed_ms != 16'hFFFF)) begin
        elapsed_ms <= elapsed_ms + 1'b1;
      end
    end
  end

  assign bus.expected      = target;
  assign bus.position      = position;
  assign bus.correct_count = correct_count;
  assign bus.error_count   = error_count;
  assign bus.elapsed_ms    = elapsed_ms;
  assign bus.busy          = busy;
  assign bus.done          = done;
  assign bus.score_valid   = score_valid;

endmodule

// File: tb/tb_typing_scorer.sv
module tb_typing_scorer;
  import typing_scorer_pkg::*;

  localparam int LEN   = 4;
  localparam int TICKS = 10;

  localparam int M_IDLE = 0, M_ARMED = 1, M_RUN = 2, M_DONE = 3;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_err;

  typing_scorer_if bus();

  typing_scorer #(
    .TEST_LEN     (LEN),
    .TICKS_PER_MS (TICKS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: scorer behaviour derived from its rules
  int m_state, m_pos, m_corr, m_err, m_run_edges, m_elapsed;
  bit m_prev_kv, m_sv;

  function automatic int m_expected();
    return (m_pos < LEN) ? int'(TARGET_SEQ[m_pos]) : 0;
  endfunction

  task automatic model_edge(input bit r, input bit s, input bit kv, input logic [3:0] kc);
    bit ev;
    if (r) begin
      m_state = M_IDLE; m_pos = 0; m_corr = 0; m_err = 0;
      m_run_edges = 0; m_elapsed = 0; m_prev_kv = 1'b1; m_sv = 1'b0;
      return;
    end
    ev = kv && !m_prev_kv;
    m_prev_kv = kv;
    m_sv = 1'b0;
    if (m_state == M_RUN) begin
      m_run_edges++;
      m_elapsed = (m_run_edges / TICKS > 65535) ? 65535 : m_run_edges / TICKS;
    end
    if (s) begin
      m_state = M_ARMED; m_pos = 0; m_corr = 0; m_err = 0;
      m_run_edges = 0; m_elapsed = 0;
    end else if (ev && (m_state == M_ARMED || m_state == M_RUN)) begin
      if (int'(kc) == m_expected()) begin
        m_pos++; m_corr++;
        if (m_pos == LEN) begin
          m_state = M_DONE; m_sv = 1'b1;
        end else begin
          m_state = M_RUN;
        end
      end else begin
        if (m_err < 255) m_err++;
        m_state = M_RUN;
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d, want %0d", name, $time, act, exp);
    end
  endtask

  task automatic compare_model();
    chk("m.position", 32'(bus.position),      32'(m_pos));
    chk("m.correct",  32'(bus.correct_count), 32'(m_corr));
    chk("m.errors",   32'(bus.error_count),   32'(m_err));
    chk("m.elapsed",  32'(bus.elapsed_ms),    32'(m_elapsed));
    chk("m.expected", 32'(bus.expected),      32'(m_expected()));
    chk("m.busy",     32'(bus.busy),  32'(m_state == M_ARMED || m_state == M_RUN));
    chk("m.done",     32'(bus.done),  32'(m_state == M_DONE));
    chk("m.score_valid", 32'(bus.score_valid), 32'(m_sv));
  endtask

  // drive one cycle of inputs, advance one edge, compare against the model
  task automatic step(input bit r, input bit s, input bit kv, input logic [3:0] kc);
    rst = r; bus.start = s; bus.key_valid = kv; bus.key_code = kc;
    @(posedge clk);
    model_edge(r, s, kv, kc);
    #1;
    compare_model();
  endtask

  task automatic press(input logic [3:0] kc);
    step(1'b0, 1'b0, 1'b1, kc);
    step(1'b0, 1'b0, 1'b0, kc);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 4'd0);
  endtask

  typedef struct {
    bit         s;
    bit         kv;
    logic [3:0] kc;
    logic [4:0] pos;
    logic [4:0] corr;
    logic [7:0] err;
    bit         busy;
    bit         done;
    bit         sv;
    logic [3:0] expd;
  } vec_t;

  vec_t vecs [14];

  initial begin
    bit kv_cur;
    logic [3:0] kc_cur;
    n_chk = 0; n_err = 0;
    rst = 1'b1; bus.start = 1'b0; bus.key_valid = 1'b0; bus.key_code = 4'd0;

    //             s  kv  kc    pos  corr err  busy done sv expd
    vecs[0]  = '{1'b1, 1'b0, 4'd0, 5'd0, 5'd0, 8'd0, 1'b1, 1'b0, 1'b0, 4'd1};
    vecs[1]  = '{1'b0, 1'b1, 4'd1, 5'd1, 5'd1, 8'd0, 1'b1, 1'b0, 1'b0, 4'd2};
    vecs[2]  = '{1'b0, 1'b0, 4'd1, 5'd1, 5'd1, 8'd0, 1'b1, 1'b0, 1'b0, 4'd2};
    vecs[3]  = '{1'b0, 1'b1, 4'd7, 5'd1, 5'd1, 8'd1, 1'b1, 1'b0, 1'b0, 4'd2};
    vecs[4]  = '{1'b0, 1'b0, 4'd7, 5'd1, 5'd1, 8'd1, 1'b1, 1'b0, 1'b0, 4'd2};
    vecs[5]  = '{1'b0, 1'b1, 4'd2, 5'd2, 5'd2, 8'd1, 1'b1, 1'b0, 1'b0, 4'd3};
    vecs[6]  = '{1'b0, 1'b0, 4'd2, 5'd2, 5'd2, 8'd1, 1'b1, 1'b0, 1'b0, 4'd3};
    vecs[7]  = '{1'b0, 1'b1, 4'd3, 5'd3, 5'd3, 8'd1, 1'b1, 1'b0, 1'b0, 4'd4};
    vecs[8]  = '{1'b0, 1'b1, 4'd3, 5'd3, 5'd3, 8'd1, 1'b1, 1'b0, 1'b0, 4'd4};
    vecs[9]  = '{1'b0, 1'b0, 4'd3, 5'd3, 5'd3, 8'd1, 1'b1, 1'b0, 1'b0, 4'd4};
    vecs[10] = '{1'b0, 1'b1, 4'd4, 5'd4, 5'd4, 8'd1, 1'b0, 1'b1, 1'b1, 4'd0};
    vecs[11] = '{1'b0, 1'b0, 4'd4, 5'd4, 5'd4, 8'd1, 1'b0, 1'b1, 1'b0, 4'd0};
    vecs[12] = '{1'b0, 1'b1, 4'd1, 5'd4, 5'd4, 8'd1, 1'b0, 1'b1, 1'b0, 4'd0};
    vecs[13] = '{1'b0, 1'b0, 4'd1, 5'd4, 5'd4, 8'd1, 1'b0, 1'b1, 1'b0, 4'd0};

    // reset state
    step(1'b1, 1'b0, 1'b0, 4'd0);
    step(1'b1, 1'b0, 1'b0, 4'd0);
    chk("rst.position", 32'(bus.position), 0);
    chk("rst.busy",     32'(bus.busy), 0);
    chk("rst.done",     32'(bus.done), 0);
    chk("rst.elapsed",  32'(bus.elapsed_ms), 0);

    // table: 1,7,2,3,4 with a held key and a key ignored in DONE
    for (int i = 0; i < 14; i++) begin
      step(1'b0, vecs[i].s, vecs[i].kv, vecs[i].kc);
      chk($sformatf("vec%0d.position", i), 32'(bus.position),      32'(vecs[i].pos));
      chk($sformatf("vec%0d.correct", i),  32'(bus.correct_count), 32'(vecs[i].corr));
      chk($sformatf("vec%0d.errors", i),   32'(bus.error_count),   32'(vecs[i].err));
      chk($sformatf("vec%0d.busy", i),     32'(bus.busy),          32'(vecs[i].busy));
      chk($sformatf("vec%0d.done", i),     32'(bus.done),          32'(vecs[i].done));
      chk($sformatf("vec%0d.score_valid", i), 32'(bus.score_valid), 32'(vecs[i].sv));
      chk($sformatf("vec%0d.expected", i), 32'(bus.expected),      32'(vecs[i].expd));
    end

    // clean run with timing: last key lands 45 edges after the first
    step(1'b1, 1'b0, 1'b0, 4'd0);
    step(1'b0, 1'b1, 1'b0, 4'd0);
    idle(25);
    chk("armed.elapsed", 32'(bus.elapsed_ms), 0);
    press(4'd1);
    press(4'd2);
    press(4'd3);
    idle(39);
    step(1'b0, 1'b0, 1'b1, 4'd4);
    chk("time.done",        32'(bus.done), 1);
    chk("time.score_valid", 32'(bus.score_valid), 1);
    chk("time.elapsed",     32'(bus.elapsed_ms), 4);
    chk("time.correct",     32'(bus.correct_count), 4);
    chk("time.errors",      32'(bus.error_count), 0);
    step(1'b0, 1'b0, 1'b0, 4'd4);
    chk("time.sv_once",     32'(bus.score_valid), 0);
    idle(30);
    chk("time.frozen",      32'(bus.elapsed_ms), 4);
    chk("time.done_hold",   32'(bus.done), 1);

    // key held through start
    step(1'b1, 1'b0, 1'b0, 4'd0);
    step(1'b0, 1'b0, 1'b1, 4'd1);
    step(1'b0, 1'b1, 1'b1, 4'd1);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b1, 4'd1);
    chk("held.position", 32'(bus.position), 0);
    chk("held.correct",  32'(bus.correct_count), 0);
    chk("held.busy",     32'(bus.busy), 1);
    step(1'b0, 1'b0, 1'b0, 4'd1);
    press(4'd1);
    chk("held.next_press", 32'(bus.position), 1);

    // start and key event together in RUN
    step(1'b1, 1'b0, 1'b0, 4'd0);
    step(1'b0, 1'b1, 1'b0, 4'd0);
    press(4'd1);
    press(4'd2);
    idle(12);
    step(1'b0, 1'b1, 1'b1, 4'd3);
    chk("restart.busy",     32'(bus.busy), 1);
    chk("restart.position", 32'(bus.position), 0);
    chk("restart.correct",  32'(bus.correct_count), 0);
    chk("restart.elapsed",  32'(bus.elapsed_ms), 0);
    step(1'b0, 1'b0, 1'b0, 4'd3);
    idle(15);
    chk("restart.armed_time", 32'(bus.elapsed_ms), 0);
    press(4'd1);
    chk("restart.first_key", 32'(bus.position), 1);

    // error saturation, then reset mid-run
    step(1'b1, 1'b0, 1'b0, 4'd0);
    step(1'b0, 1'b1, 1'b0, 4'd0);
    for (int i = 0; i < 300; i++) press(4'd0);
    chk("sat.errors",   32'(bus.error_count), 255);
    chk("sat.position", 32'(bus.position), 0);
    press(4'd1);
    step(1'b1, 1'b0, 1'b0, 4'd0);
    chk("abort.busy",        32'(bus.busy), 0);
    chk("abort.errors",      32'(bus.error_count), 0);
    chk("abort.position",    32'(bus.position), 0);
    chk("abort.score_valid", 32'(bus.score_valid), 0);
    step(1'b0, 1'b0, 1'b0, 4'd0);
    chk("abort.sv_after",    32'(bus.score_valid), 0);
    chk("abort.idle",        32'(bus.done), 0);

    // randomized traffic against the model
    kv_cur = 1'b0;
    kc_cur = 4'd0;
    for (int i = 0; i < 6000; i++) begin
      bit r, s;
      r = ($urandom_range(0, 1499) == 0);
      s = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 2) == 0) begin
        kv_cur = ~kv_cur;
        if (kv_cur)
          kc_cur = ($urandom_range(0, 3) != 0) ? 4'(m_expected()) : 4'($urandom_range(0, 15));
      end
      step(r, s, kv_cur, kc_cur);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/typing_scorer.md
TYPING_SCORER -- requirements
Module: typing_scorer

Interface
REQ-001 SHALL have parameter TEST_LEN, default 16, meaning the number of target digits per test (1..16).
REQ-002 SHALL have parameter TICKS_PER_MS, default 100_000, meaning clk cycles per millisecond (100 MHz).
REQ-003 SHALL have port clk  input  1  system clock; the block has one clock only.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port start  input  1  one-cycle pulse that arms or restarts a test.
REQ-006 SHALL have port key_code  input  4  decoded key value from the keypad decoder.
REQ-007 SHALL have port key_valid  input  1  level, high while the decoder reports a held key.
REQ-008 SHALL have port expected  output  4  target digit at the current position.
REQ-009 SHALL have port position  output  5  index of the next digit to type.
REQ-010 SHALL have port correct_count  output  5  correct keystrokes this test.
REQ-011 SHALL have port error_count  output  8  wrong keystrokes this test, saturating.
REQ-012 SHALL have port elapsed_ms  output  16  test time in ms, saturating.
REQ-013 SHALL have port busy  output  1  high in ARMED or RUN.
REQ-014 SHALL have port done  output  1  high in DONE.
REQ-015 SHALL have port score_valid  output  1  one-cycle pulse on entry to DONE.

Function
REQ-016 SHALL register key_valid every cycle in every state; key event = key_valid high AND registered copy low.
REQ-017 SHALL sample key_code in the event cycle; key_code is valid in that cycle because the decoder updates code and valid on the same edge.
REQ-018 SHALL implement FSM IDLE, ARMED, RUN, DONE.
REQ-019 IDLE: on start -> ARMED; clear position, correct_count, error_count, elapsed_ms and the prescaler.
REQ-020 ARMED: first key event -> RUN; score that key per REQ-022; elapsed_ms stays 0.
REQ-021 RUN: prescaler counts 0..TICKS_PER_MS-1; on wrap elapsed_ms increments, saturating at 0xFFFF.
REQ-022 Key event in ARMED/RUN: if key_code == target[position], position and correct_count increment; otherwise error_count increments (saturating at 255) and position holds.
REQ-023 When a correct key makes position == TEST_LEN: enter DONE on the same edge; freeze elapsed_ms; pulse score_valid for exactly one cycle.
REQ-024 DONE: all counters hold; key events are ignored; start -> ARMED with a clear per REQ-019.
REQ-025 start in ARMED or RUN SHALL restart: go to ARMED and clear per REQ-019.
REQ-026 start and a key event in the same cycle: start wins and the key is discarded.
REQ-027 Key events in IDLE SHALL be ignored.
REQ-028 A key held through start SHALL produce no event until it is released and pressed again.
REQ-029 expected SHALL equal target[position] combinationally from registered position; it is 0 when position == TEST_LEN.
REQ-030 Counter and status outputs SHALL update on the edge that samples the event, one cycle after key_valid first goes high.

Reset
REQ-031 rst SHALL force IDLE; position=0, correct_count=0, error_count=0, elapsed_ms=0, prescaler=0, busy=0, done=0, score_valid=0, registered key_valid=1.
REQ-032 rst mid-test SHALL abort without a score_valid pulse; rst has priority over start.

Structure
REQ-033 The shared package SHALL hold the FSM state encoding, the TARGET_SEQ constant (16 x 4-bit digits), and the default TICKS_PER_MS.
REQ-034 The ms prescaler SHALL be a sub-module ms_tick_gen (inputs clk, rst, clear, enable; output tick).

Verification (TICKS_PER_MS=10, TEST_LEN=4, TARGET_SEQ starts 1,2,3,4)
REQ-035 Press 1,2,3,4 correctly after start -> position 0..4; correct_count=4; error_count=0; score_valid pulses once; done=1.
REQ-036 Sequence 1,7,2,3,4 -> error_count=1; correct_count=4; position holds at 1 after the 7.
REQ-037 Wait 45 cycles after the first key, then finish -> elapsed_ms=4 (start-of-RUN prescaler alignment per REQ-021); value frozen in DONE.
REQ-038 key_valid high at start, held 20 cycles, then released -> no counter changes; next press scores normally.
REQ-039 start and key event in the same cycle during RUN -> state ARMED; all counters 0; key discarded.
REQ-040 300 wrong keys -> error_count saturates at 255; rst mid-RUN -> IDLE, all outputs 0, no score_valid.
